// File: rtl/quad_wr_dispatch.sv
// Four-entry write queue that issues up to two RAM writes per cycle on ports A and B, and drops the older write of a same-address pair.
// A request accepted at edge k can be written at edge k+1. in_ready falls while the queue is full. stall holds dispatch but pushes are still accepted.
module quad_wr_dispatch #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] wraddr_a,
    output logic [ADDR_WIDTH-1:0] wraddr_b,
    output logic [DATA_WIDTH-1:0] wrdat_a,
    output logic [DATA_WIDTH-1:0] wrdat_b,
    output logic                  we_a,
    output logic                  we_b,
    output logic [2:0]            count,
    output logic [15:0]           coll_cnt
);

    logic [ADDR_WIDTH-1:0] r_q_addr [4];
    logic [DATA_WIDTH-1:0] r_q_data [4];
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_wr_ptr;
    logic [2:0]            r_count;
    logic [ADDR_WIDTH-1:0] r_wraddr_a, r_wraddr_b;
    logic [DATA_WIDTH-1:0] r_wrdat_a, r_wrdat_b;
    logic                  r_we_a, r_we_b;
    logic [15:0]           r_coll_cnt;

    logic       w_push;
    logic       w_pop1;
    logic       w_pop2;
    logic       w_coll;
    logic       w_wr_a;
    logic [1:0] w_nxt_ptr;
    logic [2:0] w_pops;

    assign in_ready  = (r_count != 3'd4) && !rst;
    assign w_push    = in_valid && in_ready;
    assign w_pop2    = !stall && (r_count >= 3'd2);
    assign w_pop1    = !stall && (r_count == 3'd1);
    assign w_nxt_ptr = r_rd_ptr + 2'd1;
    // Older entry of a same-address pair would be overwritten anyway; skip it.
    assign w_coll    = w_pop2 && (r_q_addr[r_rd_ptr] == r_q_addr[w_nxt_ptr]);
    assign w_wr_a    = (w_pop2 && !w_coll) || w_pop1;
    assign w_pops    = w_pop2 ? 3'd2 : (w_pop1 ? 3'd1 : 3'd0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr] <= in_addr;
            r_q_data[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_we_a     <= 1'b0;
            r_we_b     <= 1'b0;
            r_wraddr_a <= '0;
            r_wraddr_b <= '0;
            r_wrdat_a  <= '0;
            r_wrdat_b  <= '0;
            r_coll_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            r_rd_ptr <= r_rd_ptr + w_pops[1:0];
            r_count  <= r_count + {2'b00, w_push} - w_pops;
            r_we_a   <= w_wr_a;
            r_we_b   <= w_pop2;
            if (w_wr_a) begin
                r_wraddr_a <= r_q_addr[r_rd_ptr];
                r_wrdat_a  <= r_q_data[r_rd_ptr];
            end
            if (w_pop2) begin
                r_wraddr_b <= r_q_addr[w_nxt_ptr];
                r_wrdat_b  <= r_q_data[w_nxt_ptr];
            end
            if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
                r_coll_cnt <= r_coll_cnt + 16'd1;
            end
        end
    end

    assign wraddr_a = r_wraddr_a;
    assign wraddr_b = r_wraddr_b;
    assign wrdat_a  = r_wrdat_a;
    assign wrdat_b  = r_wrdat_b;
    assign we_a     = r_we_a;
    assign we_b     = r_we_b;
    assign count    = r_count;
    assign coll_cnt = r_coll_cnt;

endmodule

// File: doc/quad_wr_dispatch.md
QUAD_WR_DISPATCH -- requirements
Module: quad_wr_dispatch

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the RAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the RAM data width.
REQ-003 Queue depth SHALL be fixed at 4 entries.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 in_valid  input  1  SHALL flag a write request on in_addr/in_data.
REQ-007 in_addr  input  ADDR_WIDTH  SHALL carry the request word address.
REQ-008 in_data  input  DATA_WIDTH  SHALL carry the request write data.
REQ-009 in_ready  output  1  SHALL indicate that a request can be accepted this cycle.
REQ-010 stall  input  1  SHALL suppress dispatch while high.
REQ-011 wraddr_a, wraddr_b  output  ADDR_WIDTH each  SHALL drive the quad-port RAM write addresses.
REQ-012 wrdat_a, wrdat_b  output  DATA_WIDTH each  SHALL drive the quad-port RAM write data.
REQ-013 we_a, we_b  output  1 each  SHALL drive the quad-port RAM write enables.
REQ-014 count  output  3  SHALL report the current queue occupancy, 0 to 4.
REQ-015 coll_cnt  output  16  SHALL report the number of same-address pair collisions.

Function
REQ-016 A request SHALL be accepted on an edge where in_valid=1 and in_ready=1, and written at the queue tail.
REQ-017 in_ready SHALL be the combinational result of (count != 4) and (rst == 0), computed from registered count only.
REQ-018 Each cycle with stall=0, the dispatch decision SHALL use the pre-edge count and queue contents.
REQ-019 count>=2 -> SHALL pop the head (older) and head+1 (younger) and present them on port A and port B respectively.
REQ-020 count==1 -> SHALL pop the head onto port A; port B SHALL have we_b=0.
REQ-021 count==0 or stall=1 -> no pop; we_a=0 and we_b=0.
REQ-022 For a two-entry pop with equal addresses, the older entry SHALL be dropped: we_a=0, port B SHALL carry the younger entry with we_b=1, and coll_cnt SHALL increment.
REQ-023 coll_cnt SHALL saturate at 16'hFFFF.
REQ-024 All RAM-side outputs SHALL be registered; a popped entry SHALL appear on the outputs for exactly one cycle, starting at the edge after the pop decision.
REQ-025 A request accepted at edge k SHALL be dispatched no earlier than edge k+1, given an empty queue and stall=0.
REQ-026 Simultaneous push and pop SHALL update count as count + push - pops; pointers SHALL wrap modulo 4.
REQ-027 Requests SHALL be dispatched in acceptance order; any two written addresses in the same cycle SHALL differ.
REQ-028 When we_x=0, wraddr_x and wrdat_x SHALL hold their previous values.
REQ-029 Pushes while stall=1 SHALL still be accepted until count reaches 4.

Reset
REQ-030 rst=1 SHALL clear count, the pointers, we_a, we_b, wraddr_a/b, wrdat_a/b and coll_cnt to 0 at the next edge.
REQ-031 While rst=1, in_ready SHALL be 0 and no request SHALL be accepted.
REQ-032 Reset mid-operation SHALL discard all queued entries, and no RAM write SHALL be issued for them.

Verification
REQ-033 Single push: addr 5'h03, data 32'hA5A5_0001 accepted at edge k -> at edge k+1, we_a=1, wraddr_a=3, wrdat_a=A5A5_0001, we_b=0; both enables return to 0 at edge k+2.
REQ-034 Pair: push addr 1 then addr 2 with stall=1, then release stall -> the same edge SHALL show we_a=1/addr 1 and we_b=1/addr 2.
REQ-035 Collision: with stall=1, push addr 7/data 11 then addr 7/data 22, then release stall -> we_a=0, we_b=1, wraddr_b=7, wrdat_b=22, coll_cnt=1.
REQ-036 Full: with stall=1, push 5 back-to-back -> the 5th request is refused with in_ready=0 and count=4; after stall release, entries SHALL drain in order over 2 cycles.
REQ-037 Reset mid-flight: count=3, assert rst for one cycle -> count=0, we_a=we_b=0, and no queued entry is ever written.
REQ-038 Random soak: random addresses, in_valid and stall, checked against a reference memory model through simple_quad -> zero read mismatches.
